// File: rtl/wm8978_reg_sched.sv
// WM8978 control-port write scheduler: power-up wait, init table, coalesced volume updates, NACK retry.
// Optional feature: define WM8978_VOL_RAMP_EN to step cur_vol by +/-1 per volume sequence.
module wm8978_reg_sched #(
    parameter int unsigned INIT_DLY  = 500000,
    parameter int unsigned REG_NUM   = 8,
    parameter int unsigned MAX_RETRY = 3,
    parameter logic [5:0]  VOL_DEF   = 6'd40
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        vol_req,
    input  logic [5:0]  vol_val,
    output logic        i2c_exec,
    output logic [15:0] i2c_data,
    input  logic        i2c_done,
    input  logic        i2c_ack,
    output logic        init_done,
    output logic        busy,
    output logic        cfg_err,
    output logic [5:0]  cur_vol
);

    localparam int CNT_W = (INIT_DLY > 1) ? $clog2(INIT_DLY) : 1;
    localparam int IDX_W = (REG_NUM > 1) ? $clog2(REG_NUM) : 1;
    localparam int RTY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

    typedef enum logic [2:0] {
        S_PWR_WAIT,
        S_LOAD,
        S_ISSUE,
        S_WAIT,
        S_NEXT,
        S_IDLE
    } state_t;

    state_t             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [IDX_W-1:0]   idx_q;
    logic [RTY_W-1:0]   retry_q;
    logic               in_vol_q;
    logic               ph_q;
    logic               skip_q;
    logic               pend_q;
    logic [5:0]         pend_val_q;
    logic               req_q;
    logic [5:0]         vol_lat_q;
    logic [5:0]         cur_vol_q;
    logic               cfg_err_q;
    logic               init_done_q;
    logic               exec_q;
    logic [15:0]        data_q;
    logic [15:0]        word_d;

    always_comb begin
        word_d = 16'h0000;
        if (in_vol_q) begin
            word_d = ph_q ? {7'd53, 3'b100, vol_lat_q} : {7'd52, 3'b000, vol_lat_q};
        end else begin
            case (int'(idx_q))
                0:       word_d = {7'd0,  9'h000};
                1:       word_d = {7'd1,  9'h01B};
                2:       word_d = {7'd2,  9'h1B0};
                3:       word_d = {7'd3,  9'h06F};
                4:       word_d = {7'd4,  9'h010};
                5:       word_d = {7'd6,  9'h000};
                6:       word_d = {7'd52, 3'b000, VOL_DEF};
                7:       word_d = {7'd53, 3'b100, VOL_DEF};
                default: word_d = 16'h0000;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_PWR_WAIT;
            cnt_q       <= '0;
            idx_q       <= '0;
            retry_q     <= '0;
            in_vol_q    <= 1'b0;
            ph_q        <= 1'b0;
            skip_q      <= 1'b0;
            pend_q      <= 1'b0;
            pend_val_q  <= '0;
            req_q       <= 1'b0;
            vol_lat_q   <= '0;
            cur_vol_q   <= VOL_DEF;
            cfg_err_q   <= 1'b0;
            init_done_q <= 1'b0;
            exec_q      <= 1'b0;
            data_q      <= '0;
        end else begin
            exec_q <= 1'b0;
            req_q  <= vol_req;
            case (state_q)
                S_PWR_WAIT: begin
                    if (cnt_q == CNT_W'(INIT_DLY - 1)) begin
                        state_q  <= S_LOAD;
                        idx_q    <= '0;
                        in_vol_q <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                S_LOAD: begin
                    data_q  <= word_d;
                    exec_q  <= 1'b1;
                    state_q <= S_ISSUE;
                end
                S_ISSUE: begin
                    state_q <= S_WAIT;
                end
                S_WAIT: begin
                    if (i2c_done) begin
                        if (!i2c_ack) begin
                            retry_q <= '0;
                            skip_q  <= 1'b0;
                            state_q <= S_NEXT;
                        end else if (retry_q < RTY_W'(MAX_RETRY)) begin
                            retry_q <= retry_q + 1'b1;
                            exec_q  <= 1'b1;
                            state_q <= S_ISSUE;
                        end else begin
                            retry_q   <= '0;
                            skip_q    <= 1'b1;
                            cfg_err_q <= 1'b1;
                            state_q   <= S_NEXT;
                        end
                    end
                end
                S_NEXT: begin
                    if (!in_vol_q) begin
                        if (idx_q == IDX_W'(REG_NUM - 1)) begin
                            init_done_q <= 1'b1;
                            state_q     <= S_IDLE;
                        end else begin
                            idx_q   <= idx_q + 1'b1;
                            state_q <= S_LOAD;
                        end
                    end else if (!ph_q) begin
                        ph_q    <= 1'b1;
                        state_q <= S_LOAD;
                    end else begin
                        // skip_q here reflects the R53 word just finished
                        if (!skip_q) cur_vol_q <= vol_lat_q;
                        in_vol_q <= 1'b0;
                        state_q  <= S_IDLE;
`ifdef WM8978_VOL_RAMP_EN
                        if (skip_q || (vol_lat_q == pend_val_q)) pend_q <= 1'b0;
`endif
                    end
                end
                S_IDLE: begin
                    // a request seen last cycle holds service off so back-to-back requests coalesce
                    if (pend_q && !req_q) begin
`ifdef WM8978_VOL_RAMP_EN
                        if (cur_vol_q == pend_val_q) begin
                            pend_q <= 1'b0;
                        end else begin
                            vol_lat_q <= (pend_val_q > cur_vol_q) ? cur_vol_q + 6'd1
                                                                  : cur_vol_q - 6'd1;
                            in_vol_q  <= 1'b1;
                            ph_q      <= 1'b0;
                            state_q   <= S_LOAD;
                        end
`else
                        pend_q    <= 1'b0;
                        vol_lat_q <= pend_val_q;
                        in_vol_q  <= 1'b1;
                        ph_q      <= 1'b0;
                        state_q   <= S_LOAD;
`endif
                    end
                end
                default: state_q <= S_PWR_WAIT;
            endcase
            // a new request always wins over any clear above, so it is never lost
            if (vol_req) begin
                pend_q     <= 1'b1;
                pend_val_q <= vol_val;
            end
        end
    end

    assign i2c_exec  = exec_q;
    assign i2c_data  = data_q;
    assign init_done = init_done_q;
    assign cfg_err   = cfg_err_q;
    assign cur_vol   = cur_vol_q;
    assign busy      = !rst && ((state_q != S_IDLE) || pend_q);

endmodule

// File: tb/tb_wm8978_reg_sched.sv
// Bench for wm8978_reg_sched: init-table scenarios from a vector table plus volume and reset sequences.
module tb_wm8978_reg_sched;

    localparam int DLY = 16;
    localparam int LAT = 20;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        vol_req = 1'b0;
    logic [5:0]  vol_val = '0;
    logic        i2c_exec;
    logic [15:0] i2c_data;
    logic        i2c_done = 1'b0;
    logic        i2c_ack = 1'b0;
    logic        init_done;
    logic        busy;
    logic        cfg_err;
    logic [5:0]  cur_vol;

    int          total = 0;
    int          bad = 0;
    logic [15:0] wlog[$];
    logic [15:0] nack_word = 16'hFFFF;
    int          nack_left = 0;
    logic [15:0] tbl [8];

    typedef struct {
        string       name;
        logic [15:0] nack_word;
        int          nack_n;
        int          exp_cnt;
        logic        exp_err;
    } scen_t;

    scen_t sc [3];

    wm8978_reg_sched #(
        .INIT_DLY (DLY),
        .REG_NUM  (8),
        .MAX_RETRY(3),
        .VOL_DEF  (6'd40)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .vol_req  (vol_req),
        .vol_val  (vol_val),
        .i2c_exec (i2c_exec),
        .i2c_data (i2c_data),
        .i2c_done (i2c_done),
        .i2c_ack  (i2c_ack),
        .init_done(init_done),
        .busy     (busy),
        .cfg_err  (cfg_err),
        .cur_vol  (cur_vol)
    );

    always #5 clk = ~clk;

    // I2C driver model: logs each word, answers after LAT cycles
    initial begin : i2c_model
        logic nk;
        forever begin
            @(negedge clk);
            i2c_done = 1'b0;
            i2c_ack  = 1'b0;
            if (i2c_exec === 1'b1) begin
                nk = (i2c_data == nack_word) && (nack_left > 0);
                if (nk) nack_left--;
                wlog.push_back(i2c_data);
                $display("t=%0t i2c write %h %s", $time, i2c_data, nk ? "nack" : "ack");
                repeat (LAT - 1) @(negedge clk);
                i2c_done = 1'b1;
                i2c_ack  = nk;
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end else begin
            $display("ok   %s = %0h", nm, act);
        end
    endtask

    task automatic do_reset();
        int cyc;
        rst     = 1'b1;
        vol_req = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_exec", i2c_exec, 0);
        chk("rst_data", i2c_data, 0);
        chk("rst_init_done", init_done, 0);
        chk("rst_busy", busy, 0);
        chk("rst_cfg_err", cfg_err, 0);
        chk("rst_cur_vol", cur_vol, 40);
        wlog.delete();
        rst = 1'b0;
        cyc = 0;
        while (cyc < DLY + 50) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) chk("busy_after_rst", busy, 1);
            if (i2c_exec) break;
        end
        chk("first_exec_cycle", cyc, DLY + 2);
    endtask

    task automatic wait_init();
        int n = 0;
        while (!init_done && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk("init_done", init_done, 1);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk("idle", busy, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: sim time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        int reps;
        int n;
        int sz;
        tbl = '{16'h0000, 16'h021B, 16'h05B0, 16'h066F, 16'h0810, 16'h0C00, 16'h6828, 16'h6B28};
        sc[0] = '{"all_ack",        16'hFFFF, 0,    8,  1'b0};
        sc[1] = '{"nack_w3_x2",     16'h066F, 2,    10, 1'b0};
        sc[2] = '{"nack_w3_always", 16'h066F, 1000, 11, 1'b1};

        for (int s = 0; s < 3; s++) begin
            nack_word = sc[s].nack_word;
            nack_left = sc[s].nack_n;
            do_reset();
            wait_init();
            chk($sformatf("%s_busy", sc[s].name), busy, 0);
            chk($sformatf("%s_cfg_err", sc[s].name), cfg_err, sc[s].exp_err);
            chk($sformatf("%s_count", sc[s].name), wlog.size(), sc[s].exp_cnt);
            k = 0;
            for (int i = 0; i < 8; i++) begin
                reps = (tbl[i] == sc[s].nack_word) ? 1 + ((sc[s].nack_n > 3) ? 3 : sc[s].nack_n) : 1;
                for (int r = 0; r < reps; r++) begin
                    if (k < wlog.size())
                        chk($sformatf("%s_word%0d", sc[s].name, k), wlog[k], tbl[i]);
                    k++;
                end
            end
            chk($sformatf("%s_cur_vol", sc[s].name), cur_vol, 40);
        end

        // burst of requests after init coalesces into one pair carrying the last value
        nack_word = 16'hFFFF;
        nack_left = 0;
        do_reset();
        wait_init();
        wlog.delete();
        @(negedge clk);
        vol_req = 1'b1; vol_val = 6'd5;
        @(negedge clk);
        vol_val = 6'd9;
        @(negedge clk);
        vol_val = 6'd12;
        @(negedge clk);
        vol_req = 1'b0;
        wait_idle();
        chk("burst_count", wlog.size(), 2);
        if (wlog.size() >= 2) begin
            chk("burst_r52", wlog[0], 16'h680C);
            chk("burst_r53", wlog[1], 16'h6B0C);
        end
        chk("burst_cur_vol", cur_vol, 12);

        // request during init is served after the table
        do_reset();
        n = 0;
        while (wlog.size() < 3 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        sz = wlog.size();
        chk("reach_word2", sz, 3);
        vol_req = 1'b1; vol_val = 6'd20;
        @(negedge clk);
        vol_req = 1'b0;
        wait_init();
        wait_idle();
        chk("init_vol_count", wlog.size(), 10);
        if (wlog.size() >= 10) begin
            chk("init_vol_r52", wlog[8], 16'h6814);
            chk("init_vol_r53", wlog[9], 16'h6B14);
        end
        chk("init_vol_cur_vol", cur_vol, 20);

        // reset while waiting for i2c_done; the late done must not disturb the restart
        do_reset();
        repeat (5) @(negedge clk);
        do_reset();
        wait_init();
        chk("rst_mid_count", wlog.size(), 8);
        chk("rst_mid_cfg_err", cfg_err, 0);
        if (wlog.size() >= 1) chk("rst_mid_word0", wlog[0], 16'h0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
